// File: rtl/vga_timing_gen.sv
// Raster timing source: free-running pixel/line counters, active-video decode,
// and hs/vs pushed through a short delay line to match registered colour paths.
module vga_timing_gen #(
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int SYNC_DELAY = 1
) (
  input  logic       vga_clk,
  input  logic       reset,
  input  logic       pix_ce,
  output logic [9:0] DrawX,
  output logic [9:0] DrawY,
  output logic       blank,
  output logic       hs,
  output logic       vs,
  output logic       line_start,
  output logic       frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);

  // Decode bounds are 11 bits so a sync pulse ending exactly at 1024 still compares correctly.
  localparam logic [10:0] H_ACT_END  = 11'(H_ACTIVE);
  localparam logic [10:0] V_ACT_END  = 11'(V_ACTIVE);
  localparam logic [10:0] HS_START   = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_END     = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] VS_START   = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS_END     = 11'(V_ACTIVE + V_FP + V_SYNC);

  logic [9:0] hc_q, hc_d;
  logic [9:0] vc_q, vc_d;
  logic       hs_raw;
  logic       vs_raw;

  always_comb begin
    hc_d = hc_q;
    vc_d = vc_q;
    if (pix_ce) begin
      if (hc_q == H_LAST) begin
        hc_d = '0;
        vc_d = (vc_q == V_LAST) ? '0 : vc_q + 10'd1;
      end else begin
        hc_d = hc_q + 10'd1;
      end
    end
  end

  always_ff @(posedge vga_clk) begin
    if (reset) begin
      hc_q <= '0;
      vc_q <= '0;
    end else begin
      hc_q <= hc_d;
      vc_q <= vc_d;
    end
  end

  assign DrawX = hc_q;
  assign DrawY = vc_q;

  assign blank  = ({1'b0, hc_q} < H_ACT_END) && ({1'b0, vc_q} < V_ACT_END);
  assign hs_raw = !(({1'b0, hc_q} >= HS_START) && ({1'b0, hc_q} < HS_END));
  assign vs_raw = !(({1'b0, vc_q} >= VS_START) && ({1'b0, vc_q} < VS_END));

  assign line_start  = !reset && (hc_q == 10'd0);
  assign frame_start = !reset && (hc_q == 10'd0) && (vc_q == 10'd0);

  generate
    if (SYNC_DELAY == 0) begin : g_no_delay
      assign hs = hs_raw;
      assign vs = vs_raw;
    end else begin : g_delay
      logic [SYNC_DELAY-1:0] hs_pipe_q;
      logic [SYNC_DELAY-1:0] vs_pipe_q;

      for (genvar gi = 0; gi < SYNC_DELAY; gi++) begin : g_stage
        logic hs_in;
        logic vs_in;

        if (gi == 0) begin : g_first
          assign hs_in = hs_raw;
          assign vs_in = vs_raw;
        end else begin : g_next
          assign hs_in = hs_pipe_q[gi-1];
          assign vs_in = vs_pipe_q[gi-1];
        end

        // Stages preload to the inactive level so the monitor never sees a spurious sync.
        always_ff @(posedge vga_clk) begin
          if (reset) begin
            hs_pipe_q[gi] <= 1'b1;
            vs_pipe_q[gi] <= 1'b1;
          end else if (pix_ce) begin
            hs_pipe_q[gi] <= hs_in;
            vs_pipe_q[gi] <= vs_in;
          end
        end
      end

      assign hs = hs_pipe_q[SYNC_DELAY-1];
      assign vs = vs_pipe_q[SYNC_DELAY-1];
    end
  endgenerate

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: three instances (default/1-step delay, default/no delay,
// small raster/3-step delay) checked every cycle against a pixel-index model.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  logic pix_ce;

  logic [9:0] d1_x, d1_y, d0_x, d0_y, sm_x, sm_y;
  logic d1_blank, d1_hs, d1_vs, d1_ls, d1_fs;
  logic d0_blank, d0_hs, d0_vs, d0_ls, d0_fs;
  logic sm_blank, sm_hs, sm_vs, sm_ls, sm_fs;

  vga_timing_gen #(.SYNC_DELAY(1)) u_d1 (
    .vga_clk(clk), .reset(reset), .pix_ce(pix_ce),
    .DrawX(d1_x), .DrawY(d1_y), .blank(d1_blank), .hs(d1_hs), .vs(d1_vs),
    .line_start(d1_ls), .frame_start(d1_fs)
  );

  vga_timing_gen #(.SYNC_DELAY(0)) u_d0 (
    .vga_clk(clk), .reset(reset), .pix_ce(pix_ce),
    .DrawX(d0_x), .DrawY(d0_y), .blank(d0_blank), .hs(d0_hs), .vs(d0_vs),
    .line_start(d0_ls), .frame_start(d0_fs)
  );

  vga_timing_gen #(
    .H_ACTIVE(20), .H_FP(2), .H_SYNC(4), .H_BP(3),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(2),
    .SYNC_DELAY(3)
  ) u_sm (
    .vga_clk(clk), .reset(reset), .pix_ce(pix_ce),
    .DrawX(sm_x), .DrawY(sm_y), .blank(sm_blank), .hs(sm_hs), .vs(sm_vs),
    .line_start(sm_ls), .frame_start(sm_fs)
  );

  int     n_assert = 0;
  int     n_fail   = 0;
  longint n_steps  = 0;
  int     hs_low_d1 = 0;
  int     blank_sm  = 0;
  int     fs_sm     = 0;

  // Expected outputs from the number of pixel steps since reset release.
  function automatic logic [24:0] model(input int ha, input int hfp, input int hsy, input int hbp,
                                        input int va, input int vfp, input int vsy, input int vbp,
                                        input int d, input longint n, input logic rst);
    int ht, vt, x, y, qx, qy;
    longint fr, p, q;
    logic bl, h, v, ls, fs;
    ht = ha + hfp + hsy + hbp;
    vt = va + vfp + vsy + vbp;
    fr = longint'(ht) * longint'(vt);
    p  = n % fr;
    x  = int'(p % ht);
    y  = int'(p / ht);
    bl = (x < ha) && (y < va);
    ls = !rst && (x == 0);
    fs = !rst && (p == 0);
    h  = 1'b1;
    v  = 1'b1;
    if (n >= d) begin
      q  = (n - d) % fr;
      qx = int'(q % ht);
      qy = int'(q / ht);
      h  = !((qx >= ha + hfp) && (qx < ha + hfp + hsy));
      v  = !((qy >= va + vfp) && (qy < va + vfp + vsy));
    end
    return {10'(x), 10'(y), bl, h, v, ls, fs};
  endfunction

  task automatic check_one(input string tag, input logic [24:0] got, input logic [24:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s step=%0d: observed x=%0d y=%0d bl/hs/vs/ls/fs=%05b, expected x=%0d y=%0d bl/hs/vs/ls/fs=%05b",
             tag, n_steps, got[24:15], got[14:5], got[4:0], exp[24:15], exp[14:5], exp[4:0]);
    end
  endtask

  task automatic check_val(input string tag, input int got, input int exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_all();
    check_one("d1", {d1_x, d1_y, d1_blank, d1_hs, d1_vs, d1_ls, d1_fs},
              model(640, 16, 96, 48, 480, 10, 2, 33, 1, n_steps, reset));
    check_one("d0", {d0_x, d0_y, d0_blank, d0_hs, d0_vs, d0_ls, d0_fs},
              model(640, 16, 96, 48, 480, 10, 2, 33, 0, n_steps, reset));
    check_one("sm", {sm_x, sm_y, sm_blank, sm_hs, sm_vs, sm_ls, sm_fs},
              model(20, 2, 4, 3, 6, 1, 2, 2, 3, n_steps, reset));
    if (d1_hs == 1'b0) hs_low_d1++;
    if (sm_blank) blank_sm++;
    if (sm_fs) fs_sm++;
  endtask

  // Apply inputs, check the settled outputs, then take one clock edge.
  task automatic cycle(input logic rst, input logic ce);
    reset  = rst;
    pix_ce = ce;
    #1;
    check_all();
    @(posedge clk);
    if (rst) n_steps = 0;
    else if (ce) n_steps++;
    #1;
  endtask

  initial begin
    reset  = 1'b1;
    pix_ce = 1'b0;
    @(posedge clk);
    #1;
    n_steps = 0;

    // Reset state, with pix_ce both low and high
    cycle(1'b1, 1'b0);
    cycle(1'b1, 1'b1);
    cycle(1'b1, 1'b0);

    // One full line at full rate
    hs_low_d1 = 0;
    for (int i = 0; i < 800; i++) cycle(1'b0, 1'b1);
    check_val("hs_low_line_full_rate", hs_low_d1, 96);

    // Half-rate pixel enable over one line
    hs_low_d1 = 0;
    for (int i = 0; i < 1600; i++) cycle(1'b0, (i % 2) == 0);
    check_val("hs_low_line_half_rate", hs_low_d1, 192);
    check_val("half_rate_line_end_y", int'(d1_y), 2);

    // Random enables with occasional resets
    for (int i = 0; i < 3000; i++) begin
      cycle($urandom_range(0, 299) == 0, $urandom_range(0, 3) != 0);
    end

    // Mid-line reset at DrawX=300 of line 1
    cycle(1'b1, 1'b0);
    for (int i = 0; i < 1100; i++) cycle(1'b0, 1'b1);
    check_val("pre_reset_x", int'(d1_x), 300);
    check_val("pre_reset_y", int'(d1_y), 1);
    cycle(1'b1, 1'b1);
    check_val("post_reset_xy", int'({d1_x, d1_y}), 0);
    check_val("post_reset_hsvs", int'({d1_hs, d1_vs}), 3);
    cycle(1'b0, 1'b1);

    // Two complete frames of the small raster
    cycle(1'b1, 1'b0);
    blank_sm = 0;
    fs_sm    = 0;
    for (int i = 0; i < 638; i++) cycle(1'b0, 1'b1);
    check_val("sm_blank_count", blank_sm, 240);
    check_val("sm_frame_start_count", fs_sm, 2);

    reset  = 1'b0;
    pix_ce = 1'b0;
    #1;
    check_all();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
